tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Multi-channel millisecond tick scheduler that shares one free-running millisecond prescaler among `N_CH` independently programmed timer channels. A sequencer walks the channels once per millisecond strobe, decrementing each enabled channel's countdown and emitting a one-cycle `tick` pulse plus a toggling `wave` output on expiry. It sits between the board clock and any consumer needing programmable slow rates: LED blink, debounce sampling, heartbeat. It replaces per-consumer divider instances.

## Interface
Parameters:
- `CLK_FREQ`, 27_000_000 — input clock frequency in Hz.
- `N_CH`, 4 — number of timer channels (≥1).
- `PERIOD_W`, 16 — width of the period in milliseconds.

Ports:
- `clk` input 1 — system clock.
- `rst_n` input 1 — reset; asynchronous, active-low.
- `cfg_valid` input 1 — configuration write request.
- `cfg_ready` output 1 — write accepted when `cfg_valid && cfg_ready`.
- `cfg_ch` input `$clog2(N_CH)` (min 1) — target channel.
- `cfg_period` input `PERIOD_W` — period in ms; 0 disables the channel.
- `cfg_enable` input 1 — channel enable.
- `cfg_oneshot` input 1 — 1 = fire once then self-disable; 0 = periodic.
- `tick` output `N_CH` — one-cycle expiry pulse per channel.
- `wave` output `N_CH` — square output; toggles on each expiry.
- `active` output `N_CH` — current enable state per channel.
- `busy` output 1 — sequencer is in SCAN.

## Operation
- Prescaler:
  - `MS_DIV = CLK_FREQ/1000`.
  - Counter runs 0..`MS_DIV-1` and wraps.
  - `ms_strobe` is high in the cycle the count equals `MS_DIV-1`.
  - The prescaler is free-running and is never affected by configuration writes.
- Per-channel state: `reload[PERIOD_W]`, `remain[PERIOD_W]`, `en`, `oneshot`, `wave`.
- FSM states:
  - IDLE: `cfg_ready`=1. On `ms_strobe`, go to SCAN with `idx`=0.
  - SCAN: `cfg_ready`=0, `busy`=1. Process channel `idx` for one cycle. `idx` increments; after `idx`=`N_CH-1`, return to IDLE.
- Scan step for channel i:
  - If `en`=0: no change.
  - Else if `remain`==1: fire. Register `tick[i]`=1 for the next cycle and toggle `wave[i]`. If oneshot, clear `en`. Otherwise reload `remain`←`reload`.
  - Else: `remain`←`remain`-1.
- Configuration write (accepted in IDLE only):
  - Sets `reload` and `remain` to `cfg_period`, and loads `oneshot`.
  - Sets `en` = `cfg_enable && (cfg_period != 0)`.
  - `wave` is not modified.
- Write and strobe in the same cycle: the write is accepted and the FSM enters SCAN on the same edge. The scan uses the newly written values.
- Static requirement: `MS_DIV > N_CH + 1` (elaboration-time assertion), so a strobe never arrives during SCAN.
- Reset values:
  - All counters and `idx` = 0; state = IDLE.
  - `tick`=0, `wave`=all 1s, `active`=0, `busy`=0, `cfg_ready`=1.
  - `reload`=`remain`=0, `en`=0.
- Reset asserted mid-SCAN aborts immediately to the reset values; no partial ticks are emitted after the asynchronous reset.

## Timing
- Let S be the `ms_strobe` cycle.
  - Channel i is scanned in cycle S+1+i.
  - `tick[i]` is high in cycle S+2+i only.
  - `wave[i]` changes on the same edge that raises `tick[i]`.
- Periodic channel with period P enabled before strobe S0 fires on its P-th scan, i.e. at S0+(P-1)·`MS_DIV`. Thereafter it fires exactly every P·`MS_DIV` clocks.
- `busy` is high for exactly `N_CH` cycles per millisecond; `cfg_ready` is its complement.
- A write is visible on `active` one cycle after acceptance.
- `remain` width is `PERIOD_W`; no wrap is possible because fire/reload happens at 1.

## Structure
- Package `tick_sched_pkg`:
  - FSM state enum (IDLE, SCAN).
  - Function computing `MS_DIV` from `CLK_FREQ`.
  - Function for the prescaler counter width (`$clog2(MS_DIV)`).
- Sub-module `ms_prescaler` (parameter `CLK_FREQ`; ports `clk`, `rst_n`, `ms_strobe`): the free-running counter, reusable by other blocks.
- Channel state held in arrays in `tick_scheduler`; the sequencer is a single always block plus a registered-output block.

## Test plan
Bench parameters: `CLK_FREQ`=10_000 (`MS_DIV`=10), `N_CH`=4, `PERIOD_W`=8.
- Reset release → `wave`=4'b1111, `tick`=0, `cfg_ready`=1; first `ms_strobe` 9 cycles after reset release; `busy` high 4 cycles per 10.
- Write ch0 periodic P=3 → `tick[0]` pulses every 30 cycles, each exactly S+2 after the strobe; `wave[0]` toggles each pulse (period 60 cycles).
- Write ch2 oneshot P=2 → exactly one `tick[2]` at S+4 of the second strobe; `active[2]` drops the same cycle; no further pulses over 200 cycles.
- Write ch1 with P=0, enable=1 → `active[1]`=0, no ticks; `cfg_valid` held during SCAN → not accepted until `cfg_ready`, values then applied.
- Write coinciding with a strobe → accepted, that SCAN uses the new `remain`; assert `rst_n` mid-SCAN → all outputs return to reset values asynchronously, no ticks after release until reprogrammed.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg
// Shared types and elaboration helpers for the millisecond tick scheduler:
//   state_t  - sequencer state (IDLE waits for a millisecond strobe,
//              SCAN walks one channel per cycle)
//   ms_div   - clocks per millisecond for a given clock frequency
//   presc_w  - width of the prescaler counter that covers 0..ms_div-1
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int ms_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // At least one bit, so a degenerate divider still elaborates.
    function automatic int presc_w(input int clk_freq);
        return (ms_div(clk_freq) > 1) ? $clog2(ms_div(clk_freq)) : 1;
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// ms_prescaler
// Free-running millisecond prescaler. The counter runs 0..MS_DIV-1 and wraps;
// ms_strobe is high for the single cycle in which the count is MS_DIV-1.
// Ports:
//   clk       in  - system clock
//   rst_n     in  - asynchronous active-low reset (count returns to 0)
//   ms_strobe out - one-cycle pulse once per millisecond
module ms_prescaler
    import tick_sched_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic ms_strobe
);

    localparam int               MS_DIV = ms_div(CLK_FREQ);
    localparam int               CNT_W  = presc_w(CLK_FREQ);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(MS_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign ms_strobe = (cnt == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
// N_CH programmable millisecond timers sharing one prescaler. Once per
// millisecond strobe the sequencer walks every channel (one per cycle),
// decrementing enabled countdowns; on expiry the channel emits a one-cycle
// tick, toggles its wave output and either reloads or (oneshot) disables.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   - config write handshake (ready only while IDLE)
//   cfg_ch                - channel to write
//   cfg_period            - period in ms, 0 disables the channel
//   cfg_enable            - channel enable
//   cfg_oneshot           - 1: fire once then disable, 0: periodic
//   tick[N_CH]            - one-cycle expiry pulse per channel
//   wave[N_CH]            - toggles on each expiry (resets high)
//   active[N_CH]          - current enable per channel
//   busy                  - sequencer is scanning
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int CLK_FREQ = 27_000_000,
    parameter  int N_CH     = 4,
    parameter  int PERIOD_W = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_enable,
    input  logic                cfg_oneshot,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     wave,
    output logic [N_CH-1:0]     active,
    output logic                busy
);

    localparam int              MS_DIV  = ms_div(CLK_FREQ);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    // A strobe must never land while a scan is still in progress.
    generate
        if (MS_DIV <= N_CH + 1) begin : g_bad_div
            $error("tick_scheduler: CLK_FREQ/1000 must exceed N_CH+1");
        end
    endgenerate

    logic ms_strobe;

    ms_prescaler #(
        .CLK_FREQ (CLK_FREQ)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .ms_strobe (ms_strobe)
    );

    state_t                         state;
    logic [CH_W-1:0]                idx;
    logic [N_CH-1:0][PERIOD_W-1:0]  reload;
    logic [N_CH-1:0][PERIOD_W-1:0]  remain;
    logic [N_CH-1:0]                en;
    logic [N_CH-1:0]                oneshot;

    logic cfg_fire;
    logic scan_fire;

    // cfg_ready is only high in IDLE, so writes never collide with scan updates.
    // Writes to channel numbers beyond N_CH-1 are dropped.
    assign cfg_fire  = cfg_valid && cfg_ready && (int'(cfg_ch) < N_CH);

    // Expiry happens at remain==1, so remain never needs to wrap through 0.
    assign scan_fire = (state == SCAN) && en[idx] && (remain[idx] == PERIOD_W'(1));

    // Sequencer and channel state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            reload    <= '0;
            remain    <= '0;
            en        <= '0;
            oneshot   <= '0;
        end else begin
            if (cfg_fire) begin
                reload[cfg_ch]  <= cfg_period;
                remain[cfg_ch]  <= cfg_period;
                oneshot[cfg_ch] <= cfg_oneshot;
                en[cfg_ch]      <= cfg_enable && (cfg_period != '0);
            end

            case (state)
                IDLE: begin
                    // A write landing with the strobe is already in the
                    // arrays by the time channel 0 is scanned.
                    if (ms_strobe) begin
                        state     <= SCAN;
                        idx       <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_fire) begin
                        if (oneshot[idx])
                            en[idx] <= 1'b0;
                        else
                            remain[idx] <= reload[idx];
                    end else if (en[idx]) begin
                        remain[idx] <= remain[idx] - 1'b1;
                    end

                    if (idx == LAST_CH) begin
                        state     <= IDLE;
                        idx       <= '0;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered outputs: tick/wave change on the edge after the scan cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            wave <= '1;
        end else begin
            tick <= '0;
            if (scan_fire) begin
                tick[idx] <= 1'b1;
                wave[idx] <= ~wave[idx];
            end
        end
    end

    assign active = en;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
// Directed bench for tick_scheduler (CLK_FREQ=10_000 -> 10 clocks per ms,
// N_CH=4, PERIOD_W=8). Cycle c counts posedges since reset release, so
// strobes fall on cycles with c%10==9 and channel i ticks in cycle S+2+i.
// Expected tick events (cycle, channel, wave after toggle) are queued as
// channels are programmed and retired by a negedge monitor.
module tb_tick_scheduler;

    localparam int N_CH = 4;

    typedef struct {
        int   c;
        int   ch;
        logic w;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic [7:0]      cfg_period;
    logic            cfg_enable;
    logic            cfg_oneshot;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] wave;
    logic [N_CH-1:0] active;
    logic            busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc;
    ev_t  sb[$];

    always #5 clk = ~clk;

    tick_scheduler #(
        .CLK_FREQ (10_000),
        .N_CH     (N_CH),
        .PERIOD_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_enable  (cfg_enable),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .wave        (wave),
        .active      (active),
        .busy        (busy)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard monitor: every tick must match a queued event, and every
    // queued event must be seen in its cycle.
    always @(negedge clk) begin
        int hit;
        if (rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (tick[ch]) begin
                    hit = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (sb[k].c == cyc && sb[k].ch == ch) hit = k;
                    tests++;
                    assert (hit >= 0) else begin
                        fails++;
                        $error("FAIL tick_unexpected ch%0d cyc %0d: got 1 want 0", ch, cyc);
                    end
                    if (hit >= 0) begin
                        tests++;
                        assert (wave[ch] === sb[hit].w) else begin
                            fails++;
                            $error("FAIL wave_at_tick ch%0d cyc %0d: got %b want %b",
                                   ch, cyc, wave[ch], sb[hit].w);
                        end
                        sb.delete(hit);
                    end
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].c <= cyc) begin
                    tests++;
                    assert (tick[sb[k].ch] === 1'b1) else begin
                        fails++;
                        $error("FAIL tick_missed ch%0d due cyc %0d: got 0 want 1", sb[k].ch, sb[k].c);
                    end
                    sb.delete(k);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc %0d: got 0x%0h want 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input int ch, input logic w);
        ev_t e;
        e.c  = c;
        e.ch = ch;
        e.w  = w;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge in an IDLE cycle; returns one negedge later.
    task automatic cfg_write(input int ch, input int period, input logic ena, input logic os);
        chk("cfg_ready_before_write", 32'(cfg_ready), 32'd1);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_period  = 8'(period);
        cfg_enable  = ena;
        cfg_oneshot = os;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tick"},   32'(tick),      32'h0);
        chk({tag, "_wave"},   32'(wave),      32'hf);
        chk({tag, "_active"}, 32'(active),    32'h0);
        chk({tag, "_busy"},   32'(busy),      32'h0);
        chk({tag, "_ready"},  32'(cfg_ready), 32'h1);
    endtask

    initial begin
        logic exp_busy;
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        cfg_enable  = 1'b0;
        cfg_oneshot = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals("release");

        // First strobe at cycle 9, so busy covers cycles 10..13, 20..23.
        for (int c = 1; c < 30; c++) begin
            wait_until(c);
            exp_busy = (c >= 10) && ((c % 10) < 4);
            chk("busy_ready_pattern", 32'({busy, cfg_ready}), 32'({exp_busy, ~exp_busy}));
        end

        // ch0 periodic P=3, written before strobe 39: fires at 61, then every 30.
        wait_until(35);
        cfg_write(0, 3, 1'b1, 1'b0);
        chk("active_after_ch0", 32'(active), 32'h1);
        push(61, 0, 1'b0);
        push(91, 0, 1'b1);
        push(121, 0, 1'b0);
        push(151, 0, 1'b1);
        wait_until(155);
        cfg_write(0, 3, 1'b0, 1'b0);
        chk("active_ch0_off", 32'(active), 32'h0);
        chk("wave_ch0_held", 32'(wave), 32'hf);

        // ch2 oneshot P=2: scanned 172 (2->1), fires on scan 182, tick 183.
        wait_until(165);
        cfg_write(2, 2, 1'b1, 1'b1);
        chk("active_ch2_on", 32'(active), 32'h4);
        push(183, 2, 1'b0);
        wait_until(182);
        chk("active_ch2_before_fire", 32'(active), 32'h4);
        wait_until(183);
        chk("active_ch2_drops", 32'(active), 32'h0);

        // ch1 with period 0 stays disabled even with enable set.
        wait_until(385);
        cfg_write(1, 0, 1'b1, 1'b0);
        chk("active_p0", 32'(active), 32'h0);

        // Hold a ch3 write through the scan 390..393; accepted at 394.
        wait_until(390);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'd3;
        cfg_period  = 8'd1;
        cfg_enable  = 1'b1;
        cfg_oneshot = 1'b0;
        for (int c = 390; c < 394; c++) begin
            wait_until(c);
            chk("ready_low_in_scan", 32'(cfg_ready), 32'h0);
            chk("held_write_not_applied", 32'(active), 32'h0);
        end
        wait_until(394);
        chk("ready_after_scan", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("held_write_applied", 32'(active), 32'h8);
        push(404, 3, 1'b0);
        push(414, 3, 1'b1);
        push(424, 3, 1'b0);

        // Write ch1 P=1 in the strobe cycle 419: that scan fires it (tick 422).
        wait_until(419);
        cfg_write(1, 1, 1'b1, 1'b0);
        chk("busy_after_strobe_write", 32'(busy), 32'h1);
        chk("active_strobe_write", 32'(active), 32'ha);
        push(422, 1, 1'b0);

        // Reset in the middle of the scan 430..433: ch1/ch3 must not tick.
        wait_until(431);
        chk("events_drained", 32'(sb.size()), 32'h0);
        chk("busy_mid_scan", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals("rerelease");
        wait_until(10);
        chk("busy_after_rerelease", 32'(busy), 32'h1);
        wait_until(120);
        chk("wave_after_rerelease", 32'(wave), 32'hf);
        chk("no_pending_events", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
